// File: rtl/countdown_timer_if.sv
// Control/preset/status bundle for countdown_timer.
// The slave side is the timer; the master side is the controller that drives it.
interface countdown_timer_if;
    logic       tick;
    logic       load;
    logic [3:0] min_t_in;
    logic [3:0] min_u_in;
    logic [3:0] sec_t_in;
    logic [3:0] sec_u_in;
    logic       start;
    logic       pause;
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
    logic       running;
    logic       done;
    logic       alarm;
    logic       load_err;

    modport slave (
        input  tick, load, min_t_in, min_u_in, sec_t_in, sec_u_in, start, pause,
        output min_t, min_u, sec_t, sec_u, running, done, alarm, load_err
    );

    modport master (
        output tick, load, min_t_in, min_u_in, sec_t_in, sec_u_in, start, pause,
        input  min_t, min_u, sec_t, sec_u, running, done, alarm, load_err
    );
endinterface

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with start/pause control and a tick-timed alarm.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | preset held, waiting for start (ignored at 00:00)
//  S_RUN   | each tick removes one second; expiry at 00:01 -> S_ALARM
//  S_PAUSE | count frozen, start resumes
//  S_ALARM | alarm high until ALARM_LEN ticks elapse or start acknowledges
module countdown_timer #(
    parameter int ALARM_LEN = 4
) (
    input  logic             CP,
    input  logic             reset,
    countdown_timer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_ALARM
    } state_t;

    localparam logic [3:0] ALARM_TC = 4'(ALARM_LEN);

    state_t     state;
    state_t     state_next;

    logic [3:0] min_t_q, min_u_q, sec_t_q, sec_u_q;
    logic [3:0] min_t_next, min_u_next, sec_t_next, sec_u_next;
    logic [3:0] alarm_cnt, alarm_cnt_next;
    logic       done_q, done_next;
    logic       load_err_q, load_err_next;
    logic       running_q, alarm_q;

    logic [3:0] dec_min_t, dec_min_u, dec_sec_t, dec_sec_u;
    logic       borrow_su, borrow_st, borrow_mu;
    logic       load_valid;
    logic       count_zero;
    logic       count_one;

    assign load_valid = (bus.min_t_in <= 4'd9) && (bus.min_u_in <= 4'd9) &&
                        (bus.sec_t_in <= 4'd5) && (bus.sec_u_in <= 4'd9);

    assign count_zero = (min_t_q == 4'd0) && (min_u_q == 4'd0) &&
                        (sec_t_q == 4'd0) && (sec_u_q == 4'd0);

    assign count_one  = (min_t_q == 4'd0) && (min_u_q == 4'd0) &&
                        (sec_t_q == 4'd0) && (sec_u_q == 4'd1);

    // One-second BCD decrement; the borrow ripples through all four digits
    // combinationally so every digit lands on the same edge.
    always_comb begin
        dec_sec_u = sec_u_q;
        dec_sec_t = sec_t_q;
        dec_min_u = min_u_q;
        dec_min_t = min_t_q;
        borrow_su = 1'b0;
        borrow_st = 1'b0;
        borrow_mu = 1'b0;

        if (sec_u_q == 4'd0) begin
            dec_sec_u = 4'd9;
            borrow_su = 1'b1;
        end else begin
            dec_sec_u = sec_u_q - 4'd1;
        end

        if (borrow_su) begin
            if (sec_t_q == 4'd0) begin
                dec_sec_t = 4'd5;
                borrow_st = 1'b1;
            end else begin
                dec_sec_t = sec_t_q - 4'd1;
            end
        end

        if (borrow_st) begin
            if (min_u_q == 4'd0) begin
                dec_min_u = 4'd9;
                borrow_mu = 1'b1;
            end else begin
                dec_min_u = min_u_q - 4'd1;
            end
        end

        if (borrow_mu) begin
            dec_min_t = min_t_q - 4'd1;
        end
    end

    // Priority per edge: load > pause > start > tick.
    always_comb begin
        state_next     = state;
        min_t_next     = min_t_q;
        min_u_next     = min_u_q;
        sec_t_next     = sec_t_q;
        sec_u_next     = sec_u_q;
        alarm_cnt_next = alarm_cnt;
        done_next      = 1'b0;
        load_err_next  = 1'b0;

        if (bus.load) begin
            if (load_valid) begin
                min_t_next     = bus.min_t_in;
                min_u_next     = bus.min_u_in;
                sec_t_next     = bus.sec_t_in;
                sec_u_next     = bus.sec_u_in;
                state_next     = S_IDLE;
                alarm_cnt_next = 4'd0;
            end else begin
                load_err_next  = 1'b1;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!bus.pause && bus.start && !count_zero) begin
                        state_next = S_RUN;
                    end
                end

                S_RUN: begin
                    if (bus.pause) begin
                        state_next = S_PAUSE;
                    end else if (bus.tick && count_one) begin
                        sec_u_next     = 4'd0;
                        state_next     = S_ALARM;
                        done_next      = 1'b1;
                        alarm_cnt_next = ALARM_TC;
                    end else if (bus.tick && !count_zero) begin
                        min_t_next = dec_min_t;
                        min_u_next = dec_min_u;
                        sec_t_next = dec_sec_t;
                        sec_u_next = dec_sec_u;
                    end
                end

                S_PAUSE: begin
                    if (!bus.pause && bus.start) begin
                        state_next = S_RUN;
                    end
                end

                S_ALARM: begin
                    if (bus.start) begin
                        state_next     = S_IDLE;
                        alarm_cnt_next = 4'd0;
                    end else if (bus.tick) begin
                        // Terminal count at 1: this tick is the ALARM_LEN-th one.
                        if (alarm_cnt <= 4'd1) begin
                            state_next     = S_IDLE;
                            alarm_cnt_next = 4'd0;
                        end else begin
                            alarm_cnt_next = alarm_cnt - 4'd1;
                        end
                    end
                end

                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CP or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            min_t_q    <= 4'd0;
            min_u_q    <= 4'd0;
            sec_t_q    <= 4'd0;
            sec_u_q    <= 4'd0;
            alarm_cnt  <= 4'd0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
            running_q  <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state      <= state_next;
            min_t_q    <= min_t_next;
            min_u_q    <= min_u_next;
            sec_t_q    <= sec_t_next;
            sec_u_q    <= sec_u_next;
            alarm_cnt  <= alarm_cnt_next;
            done_q     <= done_next;
            load_err_q <= load_err_next;
            running_q  <= (state_next == S_RUN);
            alarm_q    <= (state_next == S_ALARM);
        end
    end

    assign bus.min_t    = min_t_q;
    assign bus.min_u    = min_u_q;
    assign bus.sec_t    = sec_t_q;
    assign bus.sec_u    = sec_u_q;
    assign bus.running  = running_q;
    assign bus.done     = done_q;
    assign bus.alarm    = alarm_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random control traffic,
// checked each cycle against a seconds-based reference model.
module tb_countdown_timer;
    localparam int ALARM_LEN = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_ALARM = 3;

    logic CP    = 1'b0;
    logic reset = 1'b0;

    countdown_timer_if tif();

    countdown_timer #(.ALARM_LEN(ALARM_LEN)) dut (
        .CP   (CP),
        .reset(reset),
        .bus  (tif)
    );

    always #5 CP = ~CP;

    int   vectors     = 0;
    int   miscompares = 0;

    int   m_secs       = 0;
    int   m_mode       = M_IDLE;
    int   m_alarm_left = 0;
    logic m_done       = 1'b0;
    logic m_lerr       = 1'b0;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int mins;
        mins = m_secs / 60;
        check("min_t",    tif.min_t, 4'(mins / 10));
        check("min_u",    tif.min_u, 4'(mins % 10));
        check("sec_t",    tif.sec_t, 4'((m_secs % 60) / 10));
        check("sec_u",    tif.sec_u, 4'(m_secs % 10));
        check("running",  {3'b000, tif.running},  {3'b000, m_mode == M_RUN});
        check("alarm",    {3'b000, tif.alarm},    {3'b000, m_mode == M_ALARM});
        check("done",     {3'b000, tif.done},     {3'b000, m_done});
        check("load_err", {3'b000, tif.load_err}, {3'b000, m_lerr});
    endtask

    // Reference behaviour over one clock edge, with the count kept as plain seconds.
    task automatic model_step(input logic ld, input logic [3:0] mt, input logic [3:0] mu,
                              input logic [3:0] st, input logic [3:0] su,
                              input logic s, input logic p, input logic t);
        m_done = 1'b0;
        m_lerr = 1'b0;
        if (ld) begin
            if (mt <= 9 && mu <= 9 && st <= 5 && su <= 9) begin
                m_secs       = (int'(mt) * 10 + int'(mu)) * 60 + int'(st) * 10 + int'(su);
                m_mode       = M_IDLE;
                m_alarm_left = 0;
            end else begin
                m_lerr = 1'b1;
            end
        end else begin
            case (m_mode)
                M_IDLE:  if (!p && s && m_secs > 0) m_mode = M_RUN;
                M_RUN: begin
                    if (p) m_mode = M_PAUSE;
                    else if (t && m_secs > 0) begin
                        m_secs = m_secs - 1;
                        if (m_secs == 0) begin
                            m_mode       = M_ALARM;
                            m_done       = 1'b1;
                            m_alarm_left = ALARM_LEN;
                        end
                    end
                end
                M_PAUSE: if (!p && s) m_mode = M_RUN;
                default: begin
                    if (s) m_mode = M_IDLE;
                    else if (t) begin
                        m_alarm_left = m_alarm_left - 1;
                        if (m_alarm_left == 0) m_mode = M_IDLE;
                    end
                end
            endcase
        end
    endtask

    task automatic cyc(input logic ld, input logic [3:0] mt, input logic [3:0] mu,
                       input logic [3:0] st, input logic [3:0] su,
                       input logic s, input logic p, input logic t);
        @(negedge CP);
        tif.load     = ld;
        tif.min_t_in = mt;
        tif.min_u_in = mu;
        tif.sec_t_in = st;
        tif.sec_u_in = su;
        tif.start    = s;
        tif.pause    = p;
        tif.tick     = t;
        model_step(ld, mt, mu, st, su, s, p, t);
        @(posedge CP);
        #1;
        tif.load  = 1'b0;
        tif.start = 1'b0;
        tif.pause = 1'b0;
        tif.tick  = 1'b0;
        check_all();
    endtask

    task automatic idle();
        cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [3:0] mt, input logic [3:0] mu,
                        input logic [3:0] st, input logic [3:0] su);
        cyc(1'b1, mt, mu, st, su, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic start();
        cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic pause();
        cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    // Tick pulse followed by a quiet cycle, so ticks stay one cycle wide.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
            idle();
        end
    endtask

    // Reset raised between edges; outputs must clear before the next edge.
    task automatic async_reset();
        @(posedge CP);
        #2;
        reset = 1'b1;
        #1;
        m_secs       = 0;
        m_mode       = M_IDLE;
        m_alarm_left = 0;
        m_done       = 1'b0;
        m_lerr       = 1'b0;
        check_all();
        @(negedge CP);
        reset = 1'b0;
    endtask

    initial begin
        logic       ld, s, p, t;
        logic [3:0] mt, mu, st, su;
        int         v;

        tif.tick = 1'b0; tif.load = 1'b0; tif.start = 1'b0; tif.pause = 1'b0;
        tif.min_t_in = 4'd0; tif.min_u_in = 4'd0; tif.sec_t_in = 4'd0; tif.sec_u_in = 4'd0;

        #2 reset = 1'b1;
        #1 check_all();
        @(negedge CP);
        reset = 1'b0;
        idle();

        // 01:00 runs all the way to expiry, then alarm for ALARM_LEN ticks.
        load(4'd0, 4'd1, 4'd0, 4'd0);
        start();
        tick(1);
        tick(59);
        tick(ALARM_LEN);

        // 10:00 -> 09:59 borrows through all four digits.
        load(4'd1, 4'd0, 4'd0, 4'd0);
        start();
        tick(1);

        // Pause holds through ticks, resume finishes.
        load(4'd0, 4'd0, 4'd0, 4'd3);
        start();
        tick(1);
        pause();
        tick(5);
        pause();
        start();
        tick(2);
        start();

        // Rejected load, then 00:00 refuses to start.
        load(4'd0, 4'd5, 4'd0, 4'd0);
        load(4'd0, 4'd5, 4'd6, 4'd0);
        idle();
        load(4'd0, 4'd0, 4'd0, 4'd0);
        start();
        idle();

        // Alarm acknowledged by start after one tick.
        load(4'd0, 4'd0, 4'd0, 4'd1);
        start();
        tick(1);
        tick(1);
        start();
        idle();

        // Simultaneous-input priorities.
        load(4'd0, 4'd0, 4'd2, 4'd0);
        cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        start();
        cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1);
        tick(1);
        cyc(1'b1, 4'd0, 4'd0, 4'd4, 4'd5, 1'b0, 1'b0, 1'b1);
        start();
        cyc(1'b1, 4'd9, 4'd9, 4'd5, 4'd9, 1'b1, 1'b0, 1'b0);
        idle();

        // Reset mid-RUN at 00:30, then mid-ALARM.
        load(4'd0, 4'd0, 4'd4, 4'd0);
        start();
        tick(10);
        async_reset();
        idle();
        load(4'd0, 4'd0, 4'd0, 4'd1);
        start();
        tick(1);
        async_reset();
        idle();
        idle();

        for (int i = 0; i < 800; i++) begin
            ld = ($urandom_range(0, 99) < 6);
            s  = ($urandom_range(0, 99) < 15);
            p  = ($urandom_range(0, 99) < 8);
            t  = ($urandom_range(0, 99) < 30);
            if (s) t = 1'b0;
            if ($urandom_range(0, 3) != 0) begin
                v  = $urandom_range(0, 20);
                mt = 4'd0;
                mu = 4'd0;
                st = 4'(v / 10);
                su = 4'(v % 10);
            end else begin
                mt = 4'($urandom_range(0, 15));
                mu = 4'($urandom_range(0, 15));
                st = 4'($urandom_range(0, 15));
                su = 4'($urandom_range(0, 15));
            end
            cyc(ld, mt, mu, st, su, s, p, t);
            if (i == 400) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter ALARM_LEN, default 4, number of tick pulses alarm stays asserted after expiry (range 1-15).
REQ-002 CP  input  1  system clock, all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 tick  input  1  1 Hz enable pulse, one CP cycle wide, synchronous to CP.
REQ-005 load  input  1  load preset digits, sampled on CP edge.
REQ-006 min_t_in, min_u_in, sec_t_in, sec_u_in  input  4 each  BCD preset digits for MM:SS.
REQ-007 start  input  1  begin or resume countdown, single-cycle strobe.
REQ-008 pause  input  1  suspend countdown, single-cycle strobe.
REQ-009 min_t, min_u, sec_t, sec_u  output  4 each  current BCD count, registered.
REQ-010 running  output  1  high while state is RUN.
REQ-011 done  output  1  one-cycle pulse on expiry.
REQ-012 alarm  output  1  level, high while state is ALARM.
REQ-013 load_err  output  1  one-cycle pulse on rejected load.

Function
REQ-014 States: IDLE, RUN, PAUSE, ALARM; encoding free; all outputs registered.
REQ-015 Priority per CP edge: reset > load > pause > start > tick.
REQ-016 Valid load: every digit <= 9 and sec_t_in <= 5; max count 99:59.
REQ-017 Valid load in any state: count <= inputs, state -> IDLE, alarm cleared, alarm tick counter cleared, done not asserted.
REQ-018 Invalid load: count and state unchanged, load_err high exactly the following cycle.
REQ-019 IDLE: start with count != 00:00 -> RUN; start with count == 00:00 ignored; tick ignored.
REQ-020 RUN: tick decrements count by one second; pause -> PAUSE with count held; start ignored.
REQ-021 Decrement: sec_u 0 -> 9 with borrow, else -1; sec_t 0 -> 5 with borrow on borrow-in; min_u 0 -> 9 with borrow; min_t decrements on borrow-in; all digits update on the same edge.
REQ-022 RUN tick with count == 00:01: count -> 00:00, state -> ALARM, done high for exactly that one following cycle.
REQ-023 Count never underflows; 00:00 is never decremented.
REQ-024 PAUSE: tick ignored, count held; start -> RUN; pause ignored.
REQ-025 ALARM: alarm high; each tick increments internal alarm counter; after ALARM_LEN ticks alarm deasserts and state -> IDLE on that tick's edge.
REQ-026 ALARM: start acknowledges -> IDLE, alarm low next cycle; pause ignored.
REQ-027 Simultaneous start and pause: pause wins (RUN -> PAUSE, PAUSE stays, IDLE stays).
REQ-028 Simultaneous tick and pause in RUN: pause wins, no decrement.
REQ-029 Simultaneous load and tick/start: load wins, no decrement, state IDLE.
REQ-030 Simultaneous start and tick in PAUSE: transition to RUN only; decrement begins on the next tick.

Reset
REQ-031 reset asserted: immediately (no CP edge) count = 00:00, state IDLE, running = 0, done = 0, alarm = 0, load_err = 0, alarm counter = 0.
REQ-032 reset mid-RUN or mid-ALARM: countdown abandoned; no done pulse generated on release.
REQ-033 After reset release, first CP edge obeys REQ-015 normally.

Verification
REQ-034 Load 01:00, start, 1 tick -> 00:59, running = 1; 59 more ticks -> 00:00, done one cycle, alarm = 1.
REQ-035 Load 10:00, start, 1 tick -> 09:59 (all four digits borrow on one edge).
REQ-036 Load 00:03, start, tick, pause, 5 ticks -> holds 00:02; start, 2 ticks -> 00:00, done pulse.
REQ-037 Load with sec_t_in = 6 while count 05:00 -> load_err pulse, count stays 05:00; load 00:00 then start -> stays IDLE.
REQ-038 Expiry with ALARM_LEN = 4: alarm high for 4 ticks then IDLE; repeat, start after 1 tick -> alarm low next cycle.
REQ-039 Assert reset asynchronously between CP edges during RUN at 00:30 -> outputs 00:00, running = 0 before next CP edge.
